// File: rtl/ow18b20_master.sv
// ow18b20_master: 1-Wire bus master for a single 18B20 sensor on an open-drain DQ.
// Each start runs reset/presence, CC, 44, conversion wait, reset/presence, CC, BE,
// then reads 9 scratchpad bytes and presents temperature/TH/TL/config.
// Optional: define OW_CRC8_CHECK_EN to add a CRC8 check over the scratchpad (crc_err).
module ow18b20_master #(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int CONV_WAIT_US = 750000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        presence_err,
  output logic [15:0] temp_raw,
  output logic [7:0]  th_reg,
  output logic [7:0]  tl_reg,
  output logic [7:0]  cfg_reg,
`ifdef OW_CRC8_CHECK_EN
  output logic        crc_err,
`endif
  inout  wire         dq
);
  typedef enum logic [2:0] {
    S_IDLE, S_RST_LOW, S_RST_HIGH, S_WR_SLOT, S_RD_SLOT, S_CONV_WAIT, S_DONE
  } state_t;

  // All times in microseconds, counted by us_cnt from state/slot entry.
  localparam logic [19:0] T_RST_LOW  = 20'd480;
  localparam logic [19:0] T_RST_HIGH = 20'd500;
  localparam logic [19:0] T_PRES     = 20'd99;  // tick that brings us_cnt to 100
  localparam logic [19:0] T_SLOT     = 20'd70;
  localparam logic [19:0] T_W0_LOW   = 20'd60;
  localparam logic [19:0] T_W1_LOW   = 20'd2;
  localparam logic [19:0] T_RD_LOW   = 20'd2;
  localparam logic [19:0] T_RD_SMP   = 20'd11;  // tick that brings us_cnt to 12
  localparam logic [19:0] T_CONV     = 20'(CONV_WAIT_US);
  localparam logic [15:0] PRE_MAX    = 16'(CLK_FREQ_MHZ - 1);

  state_t      state, next_state;
  logic [15:0] pre_cnt;
  logic        us_tick;
  logic [19:0] us_cnt;
  logic [6:0]  bit_cnt;
  logic [2:0]  phase;
  logic [71:0] sr;
  logic [7:0]  wr_byte;
  logic        dq_meta, dq_s, dq_oe;
  logic        clr, slot_next, phase_next, pres_fail, rd_sample, rd_ok, accept;

  // Phase order: 0 rst, 1 CC, 2 44, 3 wait, 4 rst, 5 CC, 6 BE, 7 read x9.
  function automatic state_t phase_state(input logic [2:0] p);
    case (p)
      3'd0, 3'd4: phase_state = S_RST_LOW;
      3'd3:       phase_state = S_CONV_WAIT;
      3'd7:       phase_state = S_RD_SLOT;
      default:    phase_state = S_WR_SLOT;
    endcase
  endfunction

  assign dq      = dq_oe ? 1'b0 : 1'bz;
  assign us_tick = (pre_cnt == PRE_MAX);
  assign accept  = (state == S_IDLE) && start;

  // Free-running prescaler producing the 1 us tick.
  always_ff @(posedge clk) begin
    if (rst || us_tick) pre_cnt <= '0;
    else                pre_cnt <= pre_cnt + 16'd1;
  end

  // Two-flop synchronizer on the bus before any sampling.
  always_ff @(posedge clk) begin
    if (rst) {dq_meta, dq_s} <= 2'b11;
    else     {dq_meta, dq_s} <= {dq, dq_meta};
  end

  // Command byte for the current write phase.
  always_comb begin
    case (phase)
      3'd2:    wr_byte = 8'h44;
      3'd6:    wr_byte = 8'hBE;
      default: wr_byte = 8'hCC;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state, bus drive and per-slot control strobes.
  always_comb begin
    next_state = state;
    dq_oe      = 1'b0;
    slot_next  = 1'b0;
    phase_next = 1'b0;
    pres_fail  = 1'b0;
    rd_sample  = 1'b0;
    rd_ok      = 1'b0;
    case (state)
      S_IDLE: if (start) next_state = S_RST_LOW;
      S_RST_LOW: begin
        dq_oe = 1'b1;
        if (us_cnt >= T_RST_LOW) next_state = S_RST_HIGH;
      end
      S_RST_HIGH: begin
        if (us_tick && us_cnt == T_PRES && dq_s) begin
          pres_fail  = 1'b1;
          next_state = S_DONE;
        end else if (us_cnt >= T_RST_HIGH) begin
          phase_next = 1'b1;
          next_state = phase_state(phase + 3'd1);
        end
      end
      S_WR_SLOT: begin
        dq_oe = us_cnt < (wr_byte[bit_cnt[2:0]] ? T_W1_LOW : T_W0_LOW);
        if (us_cnt >= T_SLOT) begin
          if (bit_cnt[2:0] == 3'd7) begin
            phase_next = 1'b1;
            next_state = phase_state(phase + 3'd1);
          end else begin
            slot_next = 1'b1;
          end
        end
      end
      S_RD_SLOT: begin
        dq_oe     = us_cnt < T_RD_LOW;
        rd_sample = us_tick && us_cnt == T_RD_SMP;
        if (us_cnt >= T_SLOT) begin
          if (bit_cnt == 7'd71) begin
            rd_ok      = 1'b1;
            next_state = S_DONE;
          end else begin
            slot_next = 1'b1;
          end
        end
      end
      S_CONV_WAIT: begin
        if (us_cnt >= T_CONV) begin
          phase_next = 1'b1;
          next_state = phase_state(phase + 3'd1);
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Time base restarts on any state change, new byte, or new slot.
  assign clr = (next_state != state) || phase_next || slot_next;

  // Timer, bit counter, phase and read shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      us_cnt  <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      sr      <= '0;
    end else begin
      if (clr)                          us_cnt <= '0;
      else if (us_tick && us_cnt != '1) us_cnt <= us_cnt + 20'd1;
      if (slot_next) bit_cnt <= bit_cnt + 7'd1;
      else if (clr)  bit_cnt <= '0;
      if (accept)          phase <= '0;
      else if (phase_next) phase <= phase + 3'd1;
      if (rd_sample) sr <= {dq_s, sr[71:1]};
    end
  end

  // User-facing status and result registers; results load only on a full read.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      presence_err <= 1'b0;
      temp_raw     <= '0;
      th_reg       <= '0;
      tl_reg       <= '0;
      cfg_reg      <= '0;
    end else begin
      done <= (next_state == S_DONE);
      if (next_state == S_DONE) busy <= 1'b0;
      else if (accept)          busy <= 1'b1;
      if (pres_fail) presence_err <= 1'b1;
      if (rd_ok) begin
        presence_err <= 1'b0;
        temp_raw     <= sr[15:0];
        th_reg       <= sr[23:16];
        tl_reg       <= sr[31:24];
        cfg_reg      <= sr[39:32];
      end
    end
  end

`ifdef OW_CRC8_CHECK_EN
  logic [7:0] crc;
  // Bit-serial Dallas CRC8 over the first 64 read bits, compared to byte8.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc     <= '0;
      crc_err <= 1'b0;
    end else begin
      if (accept) crc <= '0;
      else if (rd_sample && bit_cnt < 7'd64)
        crc <= {1'b0, crc[7:1]} ^ ((crc[0] ^ dq_s) ? 8'h8C : 8'h00);
      if (rd_ok)          crc_err <= (crc != sr[71:64]);
      else if (pres_fail) crc_err <= 1'b0;
    end
  end
`endif
endmodule
